// File: rtl/swd_pkg.sv
// Shared definitions for the SWD transfer engine.
// Holds the ACK response codes, the engine state encoding, the line-reset
// length and the helpers that build the 8-bit request header.
package swd_pkg;

  localparam logic [2:0] ACK_OK    = 3'b001;
  localparam logic [2:0] ACK_WAIT  = 3'b010;
  localparam logic [2:0] ACK_FAULT = 3'b100;

  localparam int LRST_BITS = 56;
  localparam int HDR_BITS  = 8;
  localparam int ACK_BITS  = 3;
  // 32 data bits followed by one parity bit
  localparam int DATA_BITS = 33;

  typedef enum logic [3:0] {
    IDLE,
    LRST,
    HDR,
    TRN1,
    ACK,
    RDATA,
    TRN2,
    WTRN,
    WDATA,
    TAIL
  } swd_state_t;

  // Even parity over APnDP, RnW, A2, A3
  function automatic logic hdr_parity(input logic apndp, input logic rnw,
                                      input logic [1:0] addr);
    return apndp ^ rnw ^ addr[0] ^ addr[1];
  endfunction

  // Header vector, bit 0 goes on the wire first:
  // start(1), APnDP, RnW, A2, A3, parity, stop(0), park(1)
  function automatic logic [7:0] hdr_bits(input logic apndp, input logic rnw,
                                          input logic [1:0] addr);
    return {1'b1, 1'b0, hdr_parity(apndp, rnw, addr), addr[1], addr[0],
            rnw, apndp, 1'b1};
  endfunction

endpackage

// File: rtl/swd_bit_clk.sv
// SWD bit clock generator.
// Each bit is sck low for CLK_DIV clks followed by sck high for CLK_DIV clks.
// Ports:
//   clk, rst_n : system clock, asynchronous active-low reset
//   en         : run the divider; when low sck is held low, phase reset
//   restart    : restart the divider at the first low clk of a bit
//   sck        : serial clock
//   rise       : high in the clk cycle at whose end sck goes high
//   fall       : high in the clk cycle at whose end sck goes low (bit end)
module swd_bit_clk #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic restart,
  output logic sck,
  output logic rise,
  output logic fall
);

  logic [7:0] div_cnt_reg;
  logic       sck_reg;
  logic       div_end;

  assign div_end = (div_cnt_reg == 8'(CLK_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_reg <= '0;
      sck_reg     <= 1'b0;
    end else if (!en || restart) begin
      div_cnt_reg <= '0;
      sck_reg     <= 1'b0;
    end else if (div_end) begin
      div_cnt_reg <= '0;
      sck_reg     <= ~sck_reg;
    end else begin
      div_cnt_reg <= div_cnt_reg + 8'd1;
    end
  end

  // Strobes deliberately ignore restart so that the FSM (which derives
  // restart from its next state) cannot form a combinational loop.
  assign rise = en && !sck_reg && div_end;
  assign fall = en &&  sck_reg && div_end;
  assign sck  = sck_reg;

endmodule

// File: rtl/swd_xfer_engine.sv
// SWD transfer engine: turns one request (transfer or line reset) into an
// SWD frame on the frontend signals and returns a single-cycle response.
// Ports:
//   clk, rst_n                  : system clock, asynchronous active-low reset
//   req_valid/req_ready         : request handshake (ready only in IDLE)
//   req_op                      : 0 = transfer, 1 = line reset
//   req_apndp/rnw/addr/wdata    : transfer fields, latched on acceptance
//   rsp_valid                   : one-clk completion pulse
//   rsp_ack/rsp_rdata/rsp_perr  : response fields, valid with rsp_valid
//   sck/mosi/frame_rst_n/rnw    : frontend drive
//   miso                        : SWDIO readback, sampled on sck rise
module swd_xfer_engine
  import swd_pkg::*;
#(
  parameter int CLK_DIV   = 4,
  parameter int IDLE_BITS = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_op,
  input  logic        req_apndp,
  input  logic        req_rnw,
  input  logic [1:0]  req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [2:0]  rsp_ack,
  output logic [31:0] rsp_rdata,
  output logic        rsp_perr,
  output logic        sck,
  output logic        mosi,
  output logic        frame_rst_n,
  output logic        rnw,
  input  logic        miso
);

  swd_state_t  state_reg, state_next;
  logic [7:0]  bit_cnt_reg;
  logic [7:0]  bit_len;
  logic        bit_last;
  logic        bit_rise, bit_fall;
  logic        ready_en_reg;
  logic        accept;
  logic        apndp_reg, rnw_reg;
  logic [1:0]  addr_reg;
  logic [31:0] wdata_reg;
  logic [2:0]  ack_reg;
  logic [31:0] rdata_reg;
  logic        perr_reg;
  logic [7:0]  hdr_vec;

  swd_bit_clk #(.CLK_DIV(CLK_DIV)) u_bit_clk (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (state_reg != IDLE),
    .restart (state_next != state_reg),
    .sck     (sck),
    .rise    (bit_rise),
    .fall    (bit_fall)
  );

  // ready_en_reg keeps req_ready low while rst_n is asserted and releases
  // it on the first clk afterwards.
  assign req_ready = (state_reg == IDLE) && ready_en_reg;
  assign accept    = req_valid && req_ready;
  assign hdr_vec   = hdr_bits(apndp_reg, rnw_reg, addr_reg);
  assign rsp_ack   = ack_reg;
  assign rsp_rdata = rdata_reg;
  assign rsp_perr  = perr_reg;

  always_comb begin
    bit_len = 8'd1;
    case (state_reg)
      LRST:          bit_len = 8'(LRST_BITS);
      HDR:           bit_len = 8'(HDR_BITS);
      ACK:           bit_len = 8'(ACK_BITS);
      RDATA, WDATA:  bit_len = 8'(DATA_BITS);
      TAIL:          bit_len = 8'(IDLE_BITS);
      default:       bit_len = 8'd1;
    endcase
    bit_last = bit_fall && (bit_cnt_reg == bit_len - 8'd1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    rsp_valid   = 1'b0;
    mosi        = 1'b0;
    frame_rst_n = 1'b1;
    rnw         = rnw_reg;
    case (state_reg)
      IDLE: begin
        frame_rst_n = 1'b0;
        rnw         = 1'b1;
        if (accept) state_next = req_op ? LRST : HDR;
      end
      LRST: begin
        frame_rst_n = 1'b0;
        rnw         = 1'b1;
        mosi        = 1'b1;
        if (bit_last) state_next = TAIL;
      end
      HDR: begin
        mosi = hdr_vec[bit_cnt_reg[2:0]];
        if (bit_last) state_next = TRN1;
      end
      TRN1: if (bit_last) state_next = ACK;
      ACK: begin
        // The third ACK bit is sampled at this bit's rise, before bit_last.
        if (bit_last) begin
          if (ack_reg == ACK_OK) state_next = rnw_reg ? RDATA : WTRN;
          else                   state_next = TRN2;
        end
      end
      RDATA: if (bit_last) state_next = TRN2;
      TRN2:  if (bit_last) state_next = TAIL;
      WTRN:  if (bit_last) state_next = WDATA;
      WDATA: begin
        mosi = (bit_cnt_reg == 8'd32) ? ^wdata_reg : wdata_reg[bit_cnt_reg[4:0]];
        if (bit_last) state_next = TAIL;
      end
      TAIL: begin
        frame_rst_n = 1'b0;
        if (bit_last) begin
          rsp_valid  = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_en_reg <= 1'b0;
      bit_cnt_reg  <= '0;
      apndp_reg    <= 1'b0;
      rnw_reg      <= 1'b1;
      addr_reg     <= '0;
      wdata_reg    <= '0;
      ack_reg      <= '0;
      rdata_reg    <= '0;
      perr_reg     <= 1'b0;
    end else begin
      ready_en_reg <= 1'b1;
      if (state_next != state_reg) bit_cnt_reg <= '0;
      else if (bit_fall)           bit_cnt_reg <= bit_cnt_reg + 8'd1;
      if (accept) begin
        apndp_reg <= req_apndp;
        rnw_reg   <= req_op ? 1'b1 : req_rnw;
        addr_reg  <= req_addr;
        wdata_reg <= req_wdata;
        ack_reg   <= '0;
        rdata_reg <= '0;
        perr_reg  <= 1'b0;
      end
      if (bit_rise) begin
        if (state_reg == ACK) begin
          ack_reg <= {miso, ack_reg[2:1]};
        end else if (state_reg == RDATA) begin
          if (bit_cnt_reg < 8'd32) rdata_reg <= {miso, rdata_reg[31:1]};
          else                     perr_reg  <= miso ^ (^rdata_reg);
        end
      end
    end
  end

endmodule

// File: doc/swd_xfer_engine.md
SWD_XFER_ENGINE -- requirements
Module: swd_xfer_engine

Interface
REQ-001 The block SHALL have parameter CLK_DIV, default 4, meaning clk cycles per sck half-period (legal range 1..255).
REQ-002 The block SHALL have parameter IDLE_BITS, default 8, meaning zero bits clocked in raw mode after each transfer.
REQ-003 The block SHALL have port clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port req_valid / req_ready, input / output, 1 bit each: request handshake.
REQ-006 The block SHALL have port req_op, input, 1 bit: 0 = transfer, 1 = line reset.
REQ-007 The block SHALL have ports req_apndp, req_rnw, req_addr[1:0] (A[3:2]) and req_wdata[31:0], all inputs: request fields.
REQ-008 The block SHALL have port rsp_valid, output, 1 bit: single-cycle completion pulse.
REQ-009 The block SHALL have ports rsp_ack[2:0], rsp_rdata[31:0] and rsp_perr, outputs: response fields, valid with rsp_valid.
REQ-010 The block SHALL have ports sck, mosi, frame_rst_n and rnw, outputs, 1 bit each, driving the SWD frontend inputs of the same names.
REQ-011 The block SHALL have port miso, input, 1 bit: SWDIO readback from the frontend.

Function
REQ-012 Bit timing: each bit = sck low for CLK_DIV clks, then sck high for CLK_DIV clks; mosi changes only at sck fall or frame start; miso sampled in the clk cycle sck rises.
REQ-013 Handshake: req_ready=1 only in IDLE; the request is accepted and all fields latched on req_valid&&req_ready; req_valid without req_ready is ignored.
REQ-014 States SHALL be IDLE, LRST, HDR, TRN1, ACK, RDATA, TRN2, WTRN, WDATA and TAIL.
REQ-015 IDLE: sck=0, mosi=0, frame_rst_n=0, rnw=1.
REQ-016 Accepting req_op=0 SHALL go to HDR; accepting req_op=1 SHALL go to LRST.
REQ-017 LRST: frame_rst_n=0; clock 56 ones, then go to TAIL; rsp_ack=3'b000.
REQ-018 HDR: frame_rst_n=1 and rnw=req_rnw for the whole frame, set at least one clk before the first sck rise.
REQ-019 HDR SHALL send 8 bits: 1, APnDP, RnW, A2, A3, even parity of those four, 0, 1.
REQ-020 TRN1: 1 bit, mosi=0. ACK: 3 bits sampled LSB first into rsp_ack.
REQ-021 ack=3'b001 with read SHALL go to RDATA: 32 data bits LSB first plus parity; rsp_perr = sampled parity != XOR(rdata); then TRN2 (1 bit).
REQ-022 ack=3'b001 with write SHALL go to WTRN (1 bit), then WDATA: 32 bits LSB first plus XOR(wdata).
REQ-023 Any ack other than 001 (WAIT 010, FAULT 100, or invalid) SHALL go through 1 turnaround bit, then TAIL; no data phase.
REQ-024 TAIL: frame_rst_n=0; clock IDLE_BITS zeros; at the end pulse rsp_valid for 1 clk and return to IDLE (req_ready rises the next cycle).
REQ-025 rsp_rdata SHALL be 0 unless the transfer was a read with ack OK; rsp_perr SHALL be 0 except in that case.
REQ-026 Each bit counter SHALL count exactly the stated bits with no wrap; the divider SHALL restart at each state entry.

Reset
REQ-027 rst_n low SHALL, at any time including mid-frame, force IDLE, sck=0, mosi=0, frame_rst_n=0, rnw=1, req_ready=0, rsp_valid=0, rsp_ack=0, rsp_rdata=0 and rsp_perr=0.
REQ-028 req_ready SHALL assert on the first clk after rst_n deasserts.
REQ-029 An interrupted transfer SHALL produce no response.

Structure
REQ-030 A shared package/include swd_pkg SHALL hold: ACK_OK/ACK_WAIT/ACK_FAULT constants, the state encoding, LRST_BITS=56, and the header-parity function.
REQ-031 One sub-module, swd_bit_clk, SHALL own the CLK_DIV divider and emit sck, a rise strobe and a fall strobe.

Verification
REQ-032 Read AP addr 2'b11, CLK_DIV=1, target ack 001, data 0xDEADBEEF with parity 0 -> header 1,1,1,1,1,0,0,1; rsp_rdata=0xDEADBEEF; rsp_perr=0; 46+8 sck rises.
REQ-033 Write DP addr 2'b01, wdata 0x00000003 -> mosi data LSB first 1,1,0...0, parity 0; rnw=0 throughout the frame; rsp_ack=001.
REQ-034 Read with target ack 010 (WAIT) -> no data phase; rsp_ack=010; rsp_rdata=0; frame_rst_n falls after 13 rises.
REQ-035 Read OK with the parity bit flipped -> rsp_perr=1 and rsp_rdata still captured.
REQ-036 Line reset request -> 56 ones then 8 zeros with frame_rst_n=0 throughout; a single rsp_valid pulse.
REQ-037 rst_n pulsed low during WDATA bit 10 -> all outputs at reset values immediately; no rsp_valid; req_ready=1 one clk after release.
